itch_msg_fifo: RTL
==================

# itch_msg_fifo

Buffers parsed ITCH message records between the `integrated` parser and the AXI-Lite register slave. Every parser `latched_valid` strobe captures the full latched record, plus a sequence number, into a first-word-fall-through FIFO. Software pops records one at a time, so back-to-back messages are no longer overwritten before they are read. Overflow is detected, counted and flagged as sticky.

## Interface
- `DEPTH`, 16: record slots; power of two, ≥ 2.
- `SEQ_W`, 32: sequence-number width.
- `DROP_W`, 16: drop-counter width.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: parser clock (`s00_axis_aclk` domain).
- `rst` in 1: synchronous active-high reset.
- `in_valid` in 1: one-cycle strobe per completed message (parser `latched_valid`).
- `in_type` in 4, `in_order_ref` in 64, `in_side` in 1, `in_shares` in 32, `in_price` in 32, `in_new_order_ref` in 64, `in_timestamp` in 48, `in_misc_data` in 64: record fields, sampled when `in_valid`=1.
- `pop` in 1: consume the head record; ignored when `out_valid`=0.
- `clear_ovf` in 1: clear `overflow` and `drop_count`.
- `out_valid` out 1: FIFO non-empty.
- `out_type`, `out_order_ref`, `out_side`, `out_shares`, `out_price`, `out_new_order_ref`, `out_timestamp`, `out_misc_data` out: head record, same widths as the inputs.
- `out_seq` out SEQ_W: sequence number of the head record.
- `count` out $clog2(DEPTH)+1: occupancy, 0..DEPTH.
- `overflow` out 1: sticky; set when a record is dropped.
- `drop_count` out DROP_W: records dropped since the last clear; saturates at all-ones.

## Operation
- Storage is a DEPTH-entry register array holding {seq, record}.
- `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits wide and wrap modulo DEPTH. The separate `count` register disambiguates full from empty.
- `seq` counter:
  - Increments by 1 on every `in_valid`, including dropped records, so software detects gaps.
  - Wraps from 2^SEQ_W−1 to 0.
  - The first record after reset carries seq 0.
- Push = `in_valid`. Pop = `pop` && `out_valid`.
- Case matrix:
  - Push only, not full: write at `wr_ptr`, then `wr_ptr`++ and `count`++.
  - Push only, full: record dropped, `overflow`←1, `drop_count`++ (saturating). Pointers and count unchanged.
  - Pop only: `rd_ptr`++, `count`−−.
  - Push + pop, non-empty (including full): both take effect, `count` unchanged, no drop.
  - Push + pop, empty: pop ignored, push accepted, `count`→1.
  - Neither: hold.
- `clear_ovf` zeroes `overflow` and `drop_count`. If a drop occurs in the same cycle, the drop wins: `overflow`=1, `drop_count`=1.
- `out_valid` = (`count`≠0).
- `out_*` and `out_seq` show the entry at `rd_ptr` when `out_valid`=1, and are forced to 0 when `out_valid`=0.

## Timing
- Reset (synchronous, takes priority over all other inputs):
  - `wr_ptr`, `rd_ptr`, `count`, `seq`, `overflow` and `drop_count` go to 0.
  - `out_valid`=0 and all `out_*`=0 in the cycle after `rst` is sampled high.
  - Array contents need no reset.
- Push latency: a record accepted at edge N is visible on `out_*` with `out_valid`=1 after edge N, i.e. one cycle.
- Pop: at edge N the head advances. The next record, or zeros if the FIFO is now empty, is visible after edge N.
- `in_valid` may be high on consecutive cycles; each high cycle is one distinct record.
- Full throughput: one push and one pop per cycle sustained indefinitely.
- Reset mid-stream discards all buffered records; `seq` restarts at 0.

## Structure
- `itch_pkg` holds:
  - the field-width localparams (TYPE_W=4, REF_W=64, QTY_W=32, PRICE_W=32, TS_W=48, MISC_W=64);
  - `itch_rec_t`, a packed struct of the eight fields (309 bits);
  - the message-type code constants shared with the parser and the AXI-Lite slave.
- Single module with no sub-module. The array is indexed on `itch_rec_t` plus seq.
- Expected size is about 150–200 lines of RTL.

## Test plan
- Reset, then push type=1, order_ref=0x1122334455667788, price=1000 → next cycle `out_valid`=1, `out_seq`=0, `count`=1, fields match. Pop → `out_valid`=0, `out_*`=0.
- 20 back-to-back pushes into DEPTH=16 with no pop → `count`=16, `overflow`=1, `drop_count`=4. Draining returns seq 0..15 in order.
- FIFO full, push and pop in the same cycle → no drop, `count` stays 16. The pushed record is read with seq 16 after 15 more pops.
- FIFO empty, push and pop in the same cycle → `count`=1, record retained.
- `clear_ovf` in the same cycle as a drop → `overflow`=1, `drop_count`=1. A later `clear_ovf` alone → both 0.
- Preload 2^SEQ_W−2 via a small SEQ_W=4 build: push 4 records → seq 14,15,0,1 (wrap).

Source files
------------

// File: rtl/itch_pkg.sv
// Shared ITCH record definitions used by the parser, the message FIFO and the
// AXI-Lite register slave.
package itch_pkg;

  localparam int TYPE_W  = 4;
  localparam int REF_W   = 64;
  localparam int QTY_W   = 32;
  localparam int PRICE_W = 32;
  localparam int TS_W    = 48;
  localparam int MISC_W  = 64;

  typedef struct packed {
    logic [TYPE_W-1:0]  msg_type;
    logic [REF_W-1:0]   order_ref;
    logic               side;
    logic [QTY_W-1:0]   shares;
    logic [PRICE_W-1:0] price;
    logic [REF_W-1:0]   new_order_ref;
    logic [TS_W-1:0]    timestamp;
    logic [MISC_W-1:0]  misc_data;
  } itch_rec_t;

  localparam int REC_W = $bits(itch_rec_t);

  // Message-type codes carried in msg_type; must stay aligned with the parser.
  localparam logic [TYPE_W-1:0] MSG_NONE           = 4'd0;
  localparam logic [TYPE_W-1:0] MSG_ADD_ORDER      = 4'd1;
  localparam logic [TYPE_W-1:0] MSG_ADD_ORDER_MPID = 4'd2;
  localparam logic [TYPE_W-1:0] MSG_EXECUTED       = 4'd3;
  localparam logic [TYPE_W-1:0] MSG_EXECUTED_PRICE = 4'd4;
  localparam logic [TYPE_W-1:0] MSG_CANCEL         = 4'd5;
  localparam logic [TYPE_W-1:0] MSG_DELETE         = 4'd6;
  localparam logic [TYPE_W-1:0] MSG_REPLACE        = 4'd7;
  localparam logic [TYPE_W-1:0] MSG_TRADE          = 4'd8;

endpackage

// File: rtl/itch_msg_fifo.sv
// First-word-fall-through FIFO of parsed ITCH records tagged with a sequence
// number; drops on full are counted and flagged until software clears them.
module itch_msg_fifo
  import itch_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SEQ_W  = 32,
  parameter int DROP_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [TYPE_W-1:0]         in_type,
  input  logic [REF_W-1:0]          in_order_ref,
  input  logic                      in_side,
  input  logic [QTY_W-1:0]          in_shares,
  input  logic [PRICE_W-1:0]        in_price,
  input  logic [REF_W-1:0]          in_new_order_ref,
  input  logic [TS_W-1:0]           in_timestamp,
  input  logic [MISC_W-1:0]         in_misc_data,
  input  logic                      pop,
  input  logic                      clear_ovf,
  output logic                      out_valid,
  output logic [TYPE_W-1:0]         out_type,
  output logic [REF_W-1:0]          out_order_ref,
  output logic                      out_side,
  output logic [QTY_W-1:0]          out_shares,
  output logic [PRICE_W-1:0]        out_price,
  output logic [REF_W-1:0]          out_new_order_ref,
  output logic [TS_W-1:0]           out_timestamp,
  output logic [MISC_W-1:0]         out_misc_data,
  output logic [SEQ_W-1:0]          out_seq,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    itch_rec_t        rec;
  } entry_t;

  entry_t              mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_count_q, drop_count_d;

  logic                not_empty;
  logic                full;
  logic                pop_en;
  logic                accept;
  logic                drop;
  itch_rec_t           in_rec;
  entry_t              head;

  always_comb begin
    in_rec = '{
      msg_type:      in_type,
      order_ref:     in_order_ref,
      side:          in_side,
      shares:        in_shares,
      price:         in_price,
      new_order_ref: in_new_order_ref,
      timestamp:     in_timestamp,
      misc_data:     in_misc_data
    };
  end

  // NOTE: every variable written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    not_empty    = (count_q != '0);
    full         = (count_q == CNT_W'(DEPTH));
    pop_en       = pop && not_empty;
    // A pop frees the slot this cycle, so a full FIFO still accepts a push.
    accept       = in_valid && (!full || pop_en);
    drop         = in_valid && full && !pop_en;

    wr_ptr_d     = wr_ptr_q + PTR_W'(accept);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop_en);
    count_d      = count_q + CNT_W'(accept) - CNT_W'(pop_en);
    seq_d        = seq_q + SEQ_W'(in_valid);

    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_ovf) begin
        drop_count_d = DROP_W'(1);
      end else if (!(&drop_count_q)) begin
        drop_count_d = drop_count_q + DROP_W'(1);
      end
    end else if (clear_ovf) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      seq_q        <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      seq_q        <= seq_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // NOTE: the storage array has no reset; count_q gates every read, so stale
  // contents are never observable and the array can map to plain registers/RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= '{seq: seq_q, rec: in_rec};
    end
  end

  always_comb begin
    head = not_empty ? mem_q[rd_ptr_q] : '0;
  end

  assign out_valid         = not_empty;
  assign out_type          = head.rec.msg_type;
  assign out_order_ref     = head.rec.order_ref;
  assign out_side          = head.rec.side;
  assign out_shares        = head.rec.shares;
  assign out_price         = head.rec.price;
  assign out_new_order_ref = head.rec.new_order_ref;
  assign out_timestamp     = head.rec.timestamp;
  assign out_misc_data     = head.rec.misc_data;
  assign out_seq           = head.seq;
  assign count             = count_q;
  assign overflow          = overflow_q;
  assign drop_count        = drop_count_q;

endmodule
